uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter_if.sv | 39 +++
 rtl/uart_tx_arbiter.sv | 150 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and TX FIFO write-port bundle for uart_tx_arbiter
//
// Signals:
//   req0/1, valid0/1, last0/1, data0/1 : requester byte streams (requester -> arbiter)
//   ready0/1                           : byte accepted this cycle (arbiter -> requester)
//   fifo_full                          : TX FIFO full flag (FIFO -> arbiter)
//   fifo_wr, fifo_w_data               : TX FIFO write port (arbiter -> FIFO)
// Modports: master = arbiter side, slave = requester/FIFO side.
interface uart_tx_arbiter_if #(
    parameter int WORD_WIDTH = 8
);
    logic                  req0;
    logic [WORD_WIDTH-1:0] data0;
    logic                  valid0;
    logic                  last0;
    logic                  ready0;
    logic                  req1;
    logic [WORD_WIDTH-1:0] data1;
    logic                  valid1;
    logic                  last1;
    logic                  ready1;
    logic                  fifo_full;
    logic                  fifo_wr;
    logic [WORD_WIDTH-1:0] fifo_w_data;

    modport master (
        input  req0, data0, valid0, last0,
        input  req1, data1, valid1, last1,
        input  fifo_full,
        output ready0, ready1, fifo_wr, fifo_w_data
    );

    modport slave (
        output req0, data0, valid0, last0,
        output req1, data1, valid1, last1,
        output fifo_full,
        input  ready0, ready1, fifo_wr, fifo_w_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-granular round-robin arbiter sharing one UART TX FIFO write port
//
// Ports:
//   clk        : system clock
//   reset      : synchronous, active-high reset
//   bus        : uart_tx_arbiter_if.master (two requester streams + TX FIFO write port)
//   gnt        : one-hot registered grant, 00 = none
//   busy       : gnt != 00
//   wdog_abort : one-cycle pulse when a stalled grant is aborted
//                (present only when UART_TX_ARB_WATCHDOG_EN is defined)
// Optional feature macro: UART_TX_ARB_WATCHDOG_EN
module uart_tx_arbiter #(
    parameter int WORD_WIDTH  = 8,
    parameter int MAX_BURST   = 16,
    parameter int WDOG_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    uart_tx_arbiter_if.master        bus,
    output logic [1:0]               gnt,
`ifdef UART_TX_ARB_WATCHDOG_EN
    output logic                     wdog_abort,
`endif
    output logic                     busy
);
    localparam int CW = $clog2(MAX_BURST + 1);

    if (MAX_BURST < 1) begin : g_bad_burst
        $error("uart_tx_arbiter: MAX_BURST must be >= 1");
    end
    if (WDOG_CYCLES < 1) begin : g_bad_wdog
        $error("uart_tx_arbiter: WDOG_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic          ptr_q, ptr_d;       // 0 favours requester 0 on a tie
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;

    logic                  granted;
    logic                  sel1;
    logic                  src_valid;
    logic                  src_last;
    logic [WORD_WIDTH-1:0] src_data;
    logic                  accept;

`ifdef UART_TX_ARB_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    logic [WW-1:0] wdog_q, wdog_d;
    logic          abort_q, abort_d;
`endif

    // Source mux: the registered state alone selects which stream feeds the FIFO.
    always_comb begin
        granted   = (state_q == GRANT0) || (state_q == GRANT1);
        sel1      = (state_q == GRANT1);
        src_valid = sel1 ? bus.valid1 : bus.valid0;
        src_last  = sel1 ? bus.last1  : bus.last0;
        src_data  = sel1 ? bus.data1  : bus.data0;
        accept    = granted && src_valid && !bus.fifo_full;
        cnt_inc   = cnt_q + CW'(1);

        bus.ready0      = accept && !sel1;
        bus.ready1      = accept && sel1;
        bus.fifo_wr     = accept;
        bus.fifo_w_data = accept ? src_data : '0;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
`ifdef UART_TX_ARB_WATCHDOG_EN
        wdog_d  = '0;
        abort_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req0 && (!bus.req1 || !ptr_q)) begin
                    state_d = GRANT0;
                end else if (bus.req1) begin
                    state_d = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                if (accept) begin
                    cnt_d = cnt_inc;
                    // Release on end of packet or when the burst budget is spent;
                    // a forced release leaves the rest of the packet for the next grant.
                    if (src_last || (cnt_inc == CW'(MAX_BURST))) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        ptr_d   = !sel1;
                    end
                end
`ifdef UART_TX_ARB_WATCHDOG_EN
                else if (!src_valid && !bus.fifo_full) begin
                    wdog_d = wdog_q + WW'(1);
                    if (wdog_d == WW'(WDOG_CYCLES)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        ptr_d   = !sel1;
                        wdog_d  = '0;
                        abort_d = 1'b1;
                    end
                end else begin
                    // FIFO full: the requester is not at fault, so hold the count.
                    wdog_d = wdog_q;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef UART_TX_ARB_WATCHDOG_EN
            wdog_q  <= '0;
            abort_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
`ifdef UART_TX_ARB_WATCHDOG_EN
            wdog_q  <= wdog_d;
            abort_q <= abort_d;
`endif
        end
    end

    assign gnt  = {state_q == GRANT1, state_q == GRANT0};
    assign busy = (state_q == GRANT0) || (state_q == GRANT1);
`ifdef UART_TX_ARB_WATCHDOG_EN
    assign wdog_abort = abort_q;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - randomized scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
    localparam int WW = 8;
    localparam int MB = 16;
    localparam int WD = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.WORD_WIDTH(WW)) bus ();
    logic [1:0] gnt;
    logic       busy;
`ifdef UART_TX_ARB_WATCHDOG_EN
    logic       wdog_abort;
`endif

    uart_tx_arbiter #(
        .WORD_WIDTH (WW),
        .MAX_BURST  (MB),
        .WDOG_CYCLES(WD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .gnt       (gnt),
`ifdef UART_TX_ARB_WATCHDOG_EN
        .wdog_abort(wdog_abort),
`endif
        .busy      (busy)
    );

    logic          req_d   [2];
    logic          valid_d [2];
    logic          last_d  [2];
    logic [WW-1:0] data_d  [2];
    logic          full_d;

    assign bus.req0      = req_d[0];
    assign bus.valid0    = valid_d[0];
    assign bus.last0     = last_d[0];
    assign bus.data0     = data_d[0];
    assign bus.req1      = req_d[1];
    assign bus.valid1    = valid_d[1];
    assign bus.last1     = last_d[1];
    assign bus.data1     = data_d[1];
    assign bus.fifo_full = full_d;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard: {last, data} per requester, pushed when a packet is issued.
    logic [WW:0] q0[$];
    logic [WW:0] q1[$];

    // Reference model: which requester owns the FIFO, who wins the next tie,
    // and how many bytes the current grant has consumed.
    int g;      // 0 none, 1 requester 0, 2 requester 1
    int fav;    // requester index favoured on a tie
    int cnt;
    bit model_on = 0;
    bit rand_full = 0;

    always @(negedge clk) begin
        if (model_on) begin : model
            logic        ew;
            logic [WW:0] it;
            int          gn;
            check("gnt", gnt, (g == 1) ? 2'b01 : (g == 2) ? 2'b10 : 2'b00);
            check("busy", busy, g != 0);
            ew = (g != 0) && valid_d[g-1] && !full_d;
            check("fifo_wr", bus.fifo_wr, ew);
            check("ready0", bus.ready0, ew && g == 1);
            check("ready1", bus.ready1, ew && g == 2);
`ifdef UART_TX_ARB_WATCHDOG_EN
            check("wdog_abort_idle", wdog_abort, 1'b0);
`endif
            gn = g;
            if (g == 0) begin
                if (req_d[0] && req_d[1]) gn = fav + 1;
                else if (req_d[0])        gn = 1;
                else if (req_d[1])        gn = 2;
                check("wdata_zero", bus.fifo_w_data, 0);
            end else if (ew) begin
                if ((g == 1 && q0.size() == 0) || (g == 2 && q1.size() == 0)) begin
                    total++;
                    $display("FAIL scoreboard_empty: write from requester %0d with nothing expected", g - 1);
                end else begin
                    it = (g == 1) ? q0.pop_front() : q1.pop_front();
                    check("wdata", bus.fifo_w_data, it[WW-1:0]);
                    cnt++;
                    if (it[WW] || cnt == MB) begin
                        fav = 2 - g;
                        gn  = 0;
                        cnt = 0;
                    end
                end
            end else begin
                check("wdata_zero", bus.fifo_w_data, 0);
            end
            g = gn;
        end
    end

    task automatic run_req(input int n, input int npkts);
        for (int p = 0; p < npkts; p++) begin
            int          len;
            logic [WW:0] pk[$];
            len = $urandom_range(1, 40);
            pk  = {};
            for (int i = 0; i < len; i++) pk.push_back({(i == len - 1), WW'($urandom)});
            foreach (pk[i]) begin
                if (n == 0) q0.push_back(pk[i]);
                else        q1.push_back(pk[i]);
            end
            req_d[n] = 1'b1;
            foreach (pk[i]) begin
                bit took;
                int guard;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                valid_d[n] = 1'b1;
                data_d[n]  = pk[i][WW-1:0];
                last_d[n]  = pk[i][WW];
                took  = 0;
                guard = 0;
                while (!took && guard < 3000) begin
                    @(negedge clk);
                    took = (n == 0) ? bus.ready0 : bus.ready1;
                    @(posedge clk); #1;
                    guard++;
                end
                if (!took) begin
                    total++;
                    $display("FAIL drv%0d_timeout: byte %0d never accepted", n, i);
                end
                valid_d[n] = 1'b0;
                last_d[n]  = 1'b0;
            end
            if (p == npkts - 1) req_d[n] = 1'b0;
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        full_d = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rand_full) begin
                if ($urandom_range(0, 39) == 0) begin
                    full_d = 1'b1;
                    repeat (4) begin @(posedge clk); #1; end
                end else begin
                    full_d = ($urandom_range(0, 99) < 15);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nw, guard, gc;
        bit seen, ab;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_d[i] = 1'b1; valid_d[i] = 1'b1; last_d[i] = 1'b0; data_d[i] = 8'hA5;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_gnt", gnt, 2'b00);
        check("reset_busy", busy, 1'b0);
        check("reset_ready0", bus.ready0, 1'b0);
        check("reset_ready1", bus.ready1, 1'b0);
        check("reset_fifo_wr", bus.fifo_wr, 1'b0);
        check("reset_wdata", bus.fifo_w_data, 0);
`ifdef UART_TX_ARB_WATCHDOG_EN
        check("reset_wdog_abort", wdog_abort, 1'b0);
`endif
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_d[i] = 1'b0; valid_d[i] = 1'b0;
        end

        // Randomized traffic from both requesters against the scoreboard model.
        g = 0; fav = 0; cnt = 0;
        model_on  = 1;
        rand_full = 1;
        fork
            run_req(0, 12);
            run_req(1, 12);
        join
        rand_full = 0;
        repeat (8) @(posedge clk);
        #1 full_d = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        model_on = 0;

        // Reset mid-grant, then a fresh grant must run a full burst from count 0.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        req_d[1] = 1'b1; valid_d[1] = 1'b1; data_d[1] = 8'h41; last_d[1] = 1'b0;
        nw = 0; guard = 0;
        while (nw < 2 && guard < 20) begin
            @(negedge clk);
            if (bus.fifo_wr) nw++;
            @(posedge clk); #1;
            guard++;
        end
        check("midrst_two_written", nw, 2);
        check("midrst_gnt_before", gnt, 2'b10);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_gnt", gnt, 2'b00);
        check("midrst_ready1", bus.ready1, 1'b0);
        check("midrst_fifo_wr", bus.fifo_wr, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("regrant_latency_idle", gnt, 2'b00);
        nw = 0; guard = 0; seen = 0;
        while (guard < 60) begin
            @(negedge clk);
            if (gnt == 2'b10) seen = 1;
            if (bus.fifo_wr) nw++;
            if (seen && gnt == 2'b00) break;
            guard++;
        end
        check("regrant_burst_len", nw, MB);
        #1;
        req_d[1] = 1'b0; valid_d[1] = 1'b0;

`ifdef UART_TX_ARB_WATCHDOG_EN
        // Stalled requester 0 is aborted after WD idle cycles; waiting requester 1 follows.
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        req_d[0] = 1'b1; req_d[1] = 1'b1;
        gc = 0; ab = 0; guard = 0;
        while (!ab && guard < 200) begin
            @(negedge clk);
            if (gnt == 2'b01) gc++;
            if (wdog_abort) begin
                ab = 1;
                check("wd_gnt_at_abort", gnt, 2'b00);
            end
            guard++;
        end
        check("wd_abort_seen", ab, 1'b1);
        check("wd_grant_cycles", gc, WD);
        @(negedge clk);
        check("wd_abort_width", wdog_abort, 1'b0);
        check("wd_next_gnt", gnt, 2'b10);
        #1;
        req_d[0] = 1'b0; req_d[1] = 1'b0;
`else
        gc = 0; ab = 0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
